// File: rtl/reg_bus_arbiter_if.sv
// Register-file access bus: one read/write request with ack and read data.
// master drives the request (read, write, addr, wdata) and receives rdata/ack;
// slave receives the request and returns rdata/ack.
interface reg_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) ();
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output read, write, addr, wdata, input rdata, ack);
  modport slave  (input read, write, addr, wdata, output rdata, ack);
endinterface

// File: rtl/reg_bus_arbiter.sv
// Shares the PWM register-file bus between two requesters (p0 = SPI decoder,
// p1 = config sequencer). Each request pulse lands in a 1-deep pending slot,
// slots are arbitrated (round-robin or fixed priority), and the winner drives
// one registered bus cycle, followed by an ack (and read data) to its owner.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   p0, p1      requester buses (slave side): read/write/addr/wdata in, rdata/ack out
//   m           register-file bus (master side): read/write/addr/wdata out, rdata in
//   overflow    sticky flag: a request hit a full, non-draining slot
module reg_bus_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 8,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  reg_bus_arbiter_if.slave         p0,
  reg_bus_arbiter_if.slave         p1,
  reg_bus_arbiter_if.master        m,
  output logic                     overflow
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } slot_t;

  slot_t [1:0]             slot_q, slot_d;
  logic                    m_read_q, m_read_d;
  logic                    m_write_q, m_write_d;
  logic [ADDR_W-1:0]       m_addr_q, m_addr_d;
  logic [DATA_W-1:0]       m_wdata_q, m_wdata_d;
  logic                    owner_q, owner_d;
  logic                    rr_q, rr_d;       // port that wins the next tie
  logic [1:0]              ack_q, ack_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic                    overflow_q, overflow_d;

  logic [1:0]              in_rd, in_wr, grant;
  logic [1:0][ADDR_W-1:0]  in_addr;
  logic [1:0][DATA_W-1:0]  in_wdata;
  logic                    win;
  logic                    unused_m_ack;

  assign in_rd    = {p1.read,  p0.read};
  assign in_wr    = {p1.write, p0.write};
  assign in_addr  = {p1.addr,  p0.addr};
  assign in_wdata = {p1.wdata, p0.wdata};
  assign unused_m_ack = m.ack;

  // Arbitration, bus issue, completion and slot capture
  always_comb begin
    slot_d     = slot_q;
    m_read_d   = 1'b0;
    m_write_d  = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    overflow_d = overflow_q;
    grant      = '0;
    win        = 1'b0;

    if (slot_q[0].valid && slot_q[1].valid) begin
      win  = FIXED_PRIO ? 1'b0 : rr_q;
      rr_d = ~win;
    end else begin
      win  = slot_q[1].valid;
    end

    if (slot_q[0].valid || slot_q[1].valid) begin
      grant[win] = 1'b1;
      m_read_d   = ~slot_q[win].wr;
      m_write_d  = slot_q[win].wr;
      m_addr_d   = slot_q[win].addr;
      m_wdata_d  = slot_q[win].wdata;
      owner_d    = win;
    end

    // The bus cycle ending at this edge completes for its owner
    if (m_read_q || m_write_q) begin
      ack_d[owner_q] = 1'b1;
      if (m_read_q) begin
        rdata_d[owner_q] = m.rdata;
      end
    end

    // A slot being granted this edge can accept a new pulse at the same time
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        slot_d[i].valid = 1'b0;
      end
      if (in_rd[i] || in_wr[i]) begin
        if (!slot_q[i].valid || grant[i]) begin
          slot_d[i].valid = 1'b1;
          slot_d[i].wr    = in_wr[i];
          slot_d[i].addr  = in_addr[i];
          slot_d[i].wdata = in_wdata[i];
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q     <= '0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      m_read_q   <= m_read_d;
      m_write_q  <= m_write_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      overflow_q <= overflow_d;
    end
  end

  assign m.read   = m_read_q;
  assign m.write  = m_write_q;
  assign m.addr   = m_addr_q;
  assign m.wdata  = m_wdata_q;
  assign p0.ack   = ack_q[0];
  assign p1.ack   = ack_q[1];
  assign p0.rdata = rdata_q[0];
  assign p1.rdata = rdata_q[1];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: dut 0 is round-robin, dut 1 fixed priority.
// Tests push expected bus cycles and acks (with cycle numbers) to per-dut
// queues; a negedge monitor pops and compares them as the DUTs produce output.
module tb_reg_bus_arbiter;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;

  typedef struct {
    int            cyc;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct {
    int            cyc;
    bit            port;
    bit            chk;
    logic [DW-1:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [3:0]    in_rd = '0;
  logic [3:0]    in_wr = '0;
  logic [AW-1:0] in_ad [4];
  logic [DW-1:0] in_wd [4];

  logic [3:0]    ack_o;
  logic [DW-1:0] rdata_o [4];
  logic [1:0]    mrd, mwr, ovf;
  logic [AW-1:0] mad [2];
  logic [DW-1:0] mwd [2];
  logic [DW-1:0] mem [64];

  bus_t bus_q [2][$];
  ack_t ack_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p_if [4] ();
  reg_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if [2] ();

  for (genvar g = 0; g < 4; g++) begin : g_port
    assign p_if[g].read  = in_rd[g];
    assign p_if[g].write = in_wr[g];
    assign p_if[g].addr  = in_ad[g];
    assign p_if[g].wdata = in_wd[g];
    assign ack_o[g]      = p_if[g].ack;
    assign rdata_o[g]    = p_if[g].rdata;
  end

  for (genvar k = 0; k < 2; k++) begin : g_bus
    assign mrd[k]       = m_if[k].read;
    assign mwr[k]       = m_if[k].write;
    assign mad[k]       = m_if[k].addr;
    assign mwd[k]       = m_if[k].wdata;
    assign m_if[k].ack  = 1'b0;
  end

  assign m_if[0].rdata = mem[mad[0]];
  assign m_if[1].rdata = 8'h00;

  always @(posedge clk) if (mwr[0]) mem[mad[0]] <= mwd[0];

  reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .p0(p_if[0]), .p1(p_if[1]), .m(m_if[0]), .overflow(ovf[0]));

  reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .p0(p_if[2]), .p1(p_if[3]), .m(m_if[1]), .overflow(ovf[1]));

  // Scoreboard monitor: invariants plus in-order bus/ack matching
  always @(negedge clk) begin
    bus_t be;
    ack_t ae;
    bit   gp;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (mrd[d] && mwr[d]) begin
        miscompares++;
        $display("FAIL strobe_excl dut%0d cyc %0d: read=1 write=1, required at most one", d, cyc);
      end
      vectors++;
      if (ack_o[2*d] && ack_o[2*d+1]) begin
        miscompares++;
        $display("FAIL ack_excl dut%0d cyc %0d: both acks high, required at most one", d, cyc);
      end
      if (mrd[d] || mwr[d]) begin
        vectors++;
        if (bus_q[d].size() == 0) begin
          miscompares++;
          $display("FAIL bus_unexpected dut%0d cyc %0d: wr=%0b addr=%0h wdata=%0h, required no bus cycle",
                   d, cyc, mwr[d], mad[d], mwd[d]);
        end else begin
          be = bus_q[d].pop_front();
          if (cyc !== be.cyc || mwr[d] !== be.wr || mad[d] !== be.addr ||
              (be.wr && mwd[d] !== be.wdata)) begin
            miscompares++;
            $display("FAIL bus_cycle dut%0d: got cyc=%0d wr=%0b addr=%0h wdata=%0h, required cyc=%0d wr=%0b addr=%0h wdata=%0h",
                     d, cyc, mwr[d], mad[d], mwd[d], be.cyc, be.wr, be.addr, be.wdata);
          end
        end
      end
      if (ack_o[2*d] || ack_o[2*d+1]) begin
        vectors++;
        gp = ack_o[2*d+1];
        if (ack_q[d].size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected dut%0d cyc %0d: ack on port %0d, required no ack", d, cyc, gp);
        end else begin
          ae = ack_q[d].pop_front();
          if (cyc !== ae.cyc || gp !== ae.port || (ae.chk && rdata_o[2*d+gp] !== ae.rdata)) begin
            miscompares++;
            $display("FAIL ack dut%0d: got cyc=%0d port=%0d rdata=%0h, required cyc=%0d port=%0d rdata=%0h",
                     d, cyc, gp, rdata_o[2*d+gp], ae.cyc, ae.port, ae.rdata);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_rd = '0;
    in_wr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic req(input int g, input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] dt);
    in_rd[g] = r;
    in_wr[g] = w;
    in_ad[g] = a;
    in_wd[g] = dt;
  endtask

  task automatic exp_bus(input int d, input int c, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] dt);
    bus_t e;
    e.cyc = c; e.wr = w; e.addr = a; e.wdata = dt;
    bus_q[d].push_back(e);
  endtask

  task automatic exp_ack(input int d, input int c, input bit p, input bit chk,
                         input logic [DW-1:0] rd);
    ack_t e;
    e.cyc = c; e.port = p; e.chk = chk; e.rdata = rd;
    ack_q[d].push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) begin
      in_ad[g] = '0;
      in_wd[g] = '0;
    end
    idle(3);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (mrd[d] !== 1'b0 || mwr[d] !== 1'b0 || mad[d] !== '0 || mwd[d] !== '0 ||
          ovf[d] !== 1'b0 || ack_o[2*d] !== 1'b0 || ack_o[2*d+1] !== 1'b0 ||
          rdata_o[2*d] !== '0 || rdata_o[2*d+1] !== '0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: rd=%0b wr=%0b addr=%0h wdata=%0h ovf=%0b ack=%0b%0b rdata=%0h/%0h, required all 0",
                 d, mrd[d], mwr[d], mad[d], mwd[d], ovf[d], ack_o[2*d+1], ack_o[2*d],
                 rdata_o[2*d], rdata_o[2*d+1]);
      end
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    int c;
    c = cyc;
    req(0, 0, 1, 6'd3, 8'hA5);
    exp_bus(0, c + 2, 1, 6'd3, 8'hA5);
    exp_ack(0, c + 3, 0, 0, 8'h00);
    tick();
    idle(5);
    vectors++;
    if (bus_q[0].size() != 0 || ack_q[0].size() != 0 || ovf[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL write_drain: pending bus=%0d ack=%0d ovf=%0b, required 0 0 0",
               bus_q[0].size(), ack_q[0].size(), ovf[0]);
    end
  endtask

  task automatic test_read();
    int c;
    c = cyc;
    req(1, 0, 1, 6'd20, 8'hCD);
    exp_bus(0, c + 2, 1, 6'd20, 8'hCD);
    exp_ack(0, c + 3, 1, 0, 8'h00);
    tick();
    idle(4);
    c = cyc;
    req(1, 1, 0, 6'd20, 8'h00);
    exp_bus(0, c + 2, 0, 6'd20, 8'h00);
    exp_ack(0, c + 3, 1, 1, 8'hCD);
    tick();
    idle(4);
    // read and write together: only the write is performed
    c = cyc;
    req(0, 1, 1, 6'd9, 8'h99);
    exp_bus(0, c + 2, 1, 6'd9, 8'h99);
    exp_ack(0, c + 3, 0, 0, 8'h00);
    tick();
    idle(4);
    c = cyc;
    req(0, 1, 0, 6'd9, 8'h00);
    exp_bus(0, c + 2, 0, 6'd9, 8'h00);
    exp_ack(0, c + 3, 0, 1, 8'h99);
    tick();
    idle(4);
    vectors++;
    if (rdata_o[1] !== 8'hCD || rdata_o[0] !== 8'h99) begin
      miscompares++;
      $display("FAIL read_hold: p0_rdata=%0h p1_rdata=%0h, required 99 CD", rdata_o[0], rdata_o[1]);
    end
    vectors++;
    if (bus_q[0].size() != 0 || ack_q[0].size() != 0) begin
      miscompares++;
      $display("FAIL read_drain: pending bus=%0d ack=%0d, required 0 0", bus_q[0].size(), ack_q[0].size());
    end
  endtask

  task automatic test_round_robin();
    int c;
    c = cyc;
    req(0, 0, 1, 6'd1, 8'h11);
    req(1, 0, 1, 6'd2, 8'h22);
    exp_bus(0, c + 2, 1, 6'd1, 8'h11);
    exp_bus(0, c + 3, 1, 6'd2, 8'h22);
    exp_ack(0, c + 3, 0, 0, 8'h00);
    exp_ack(0, c + 4, 1, 0, 8'h00);
    tick();
    idle(5);
    c = cyc;
    req(0, 0, 1, 6'd1, 8'h33);
    req(1, 0, 1, 6'd2, 8'h44);
    exp_bus(0, c + 2, 1, 6'd2, 8'h44);
    exp_bus(0, c + 3, 1, 6'd1, 8'h33);
    exp_ack(0, c + 3, 1, 0, 8'h00);
    exp_ack(0, c + 4, 0, 0, 8'h00);
    tick();
    idle(5);
    vectors++;
    if (bus_q[0].size() != 0 || ack_q[0].size() != 0) begin
      miscompares++;
      $display("FAIL rr_drain: pending bus=%0d ack=%0d, required 0 0", bus_q[0].size(), ack_q[0].size());
    end
  endtask

  task automatic test_fixed_prio();
    int c;
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      req(2, 0, 1, 6'(8 + r), 8'(8'h50 + r));
      req(3, 0, 1, 6'(16 + r), 8'(8'h60 + r));
      exp_bus(1, c + 2, 1, 6'(8 + r), 8'(8'h50 + r));
      exp_bus(1, c + 3, 1, 6'(16 + r), 8'(8'h60 + r));
      exp_ack(1, c + 3, 0, 0, 8'h00);
      exp_ack(1, c + 4, 1, 0, 8'h00);
      tick();
      idle(5);
    end
    vectors++;
    if (bus_q[1].size() != 0 || ack_q[1].size() != 0 || ovf[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL fp_drain: pending bus=%0d ack=%0d ovf=%0b, required 0 0 0",
               bus_q[1].size(), ack_q[1].size(), ovf[1]);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    c = cyc;
    req(0, 0, 1, 6'd4, 8'h44);
    exp_bus(0, c + 2, 1, 6'd4, 8'h44);
    exp_bus(0, c + 3, 1, 6'd5, 8'h55);
    exp_ack(0, c + 3, 0, 0, 8'h00);
    exp_ack(0, c + 4, 0, 0, 8'h00);
    tick();
    req(0, 0, 1, 6'd5, 8'h55);
    tick();
    idle(5);
    vectors++;
    if (bus_q[0].size() != 0 || ack_q[0].size() != 0 || ovf[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: pending bus=%0d ack=%0d ovf=%0b, required 0 0 0",
               bus_q[0].size(), ack_q[0].size(), ovf[0]);
    end
  endtask

  task automatic test_overflow();
    int c;
    // contested round won by p0 hands the next tie to p1
    c = cyc;
    req(0, 0, 1, 6'd10, 8'hA0);
    req(1, 0, 1, 6'd11, 8'hB1);
    exp_bus(0, c + 2, 1, 6'd10, 8'hA0);
    exp_bus(0, c + 3, 1, 6'd11, 8'hB1);
    exp_ack(0, c + 3, 0, 0, 8'h00);
    exp_ack(0, c + 4, 1, 0, 8'h00);
    tick();
    idle(5);
    c = cyc;
    req(0, 0, 1, 6'd12, 8'hC2);
    req(1, 0, 1, 6'd13, 8'hD3);
    exp_bus(0, c + 2, 1, 6'd13, 8'hD3);
    exp_bus(0, c + 3, 1, 6'd12, 8'hC2);
    exp_ack(0, c + 3, 1, 0, 8'h00);
    exp_ack(0, c + 4, 0, 0, 8'h00);
    tick();
    vectors++;
    if (ovf[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_early: overflow=%0b, required 0", ovf[0]);
    end
    req(0, 0, 1, 6'd14, 8'hE4);
    tick();
    vectors++;
    if (ovf[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: overflow=%0b, required 1", ovf[0]);
    end
    idle(5);
    vectors++;
    if (ovf[0] !== 1'b1 || ovf[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_sticky: overflow dut0=%0b dut1=%0b, required 1 0", ovf[0], ovf[1]);
    end
    vectors++;
    if (bus_q[0].size() != 0 || ack_q[0].size() != 0) begin
      miscompares++;
      $display("FAIL ovf_drain: pending bus=%0d ack=%0d, required 0 0", bus_q[0].size(), ack_q[0].size());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    // contested round won by p0 leaves the pointer favouring p1
    c = cyc;
    req(0, 0, 1, 6'd17, 8'h17);
    req(1, 0, 1, 6'd18, 8'h18);
    exp_bus(0, c + 2, 1, 6'd17, 8'h17);
    exp_bus(0, c + 3, 1, 6'd18, 8'h18);
    exp_ack(0, c + 3, 0, 0, 8'h00);
    exp_ack(0, c + 4, 1, 0, 8'h00);
    tick();
    idle(5);
    req(0, 1, 0, 6'd3, 8'h00);
    req(3, 0, 1, 6'd7, 8'h77);
    tick();
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (mrd[d] !== 1'b0 || mwr[d] !== 1'b0 || mad[d] !== '0 || mwd[d] !== '0 ||
          ovf[d] !== 1'b0 || ack_o[2*d] !== 1'b0 || ack_o[2*d+1] !== 1'b0 ||
          rdata_o[2*d] !== '0 || rdata_o[2*d+1] !== '0) begin
        miscompares++;
        $display("FAIL midreset_state dut%0d: rd=%0b wr=%0b addr=%0h wdata=%0h ovf=%0b ack=%0b%0b rdata=%0h/%0h, required all 0",
                 d, mrd[d], mwr[d], mad[d], mwd[d], ovf[d], ack_o[2*d+1], ack_o[2*d],
                 rdata_o[2*d], rdata_o[2*d+1]);
      end
    end
    rst_n = 1'b1;
    idle(5);
    // pointer is back to favouring p0
    c = cyc;
    req(0, 0, 1, 6'd21, 8'h21);
    req(1, 0, 1, 6'd22, 8'h22);
    exp_bus(0, c + 2, 1, 6'd21, 8'h21);
    exp_bus(0, c + 3, 1, 6'd22, 8'h22);
    exp_ack(0, c + 3, 0, 0, 8'h00);
    exp_ack(0, c + 4, 1, 0, 8'h00);
    tick();
    idle(5);
    vectors++;
    if (bus_q[0].size() != 0 || ack_q[0].size() != 0 ||
        bus_q[1].size() != 0 || ack_q[1].size() != 0) begin
      miscompares++;
      $display("FAIL midreset_drain: pending bus=%0d/%0d ack=%0d/%0d, required all 0",
               bus_q[0].size(), bus_q[1].size(), ack_q[0].size(), ack_q[1].size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_fixed_prio();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
